// File: rtl/vga_plot_sink_if.sv
// Plot-stream and read-port bundle between the VGA plot driver (master) and vga_plot_sink (slave).
interface vga_plot_sink_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        ready;
  logic        rd_valid;
  logic [2:0]  rd_data;
  logic [14:0] lit_count;
  logic [7:0]  oob_count;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, rd_req, rd_x, rd_y,
    input  ready, rd_valid, rd_data, lit_count, oob_count
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, rd_req, rd_x, rd_y,
    output ready, rd_valid, rd_data, lit_count, oob_count
  );
endinterface

// File: rtl/vga_plot_sink.sv
// Shadow framebuffer for the VGA plot stream with lit-pixel count and a registered read port.
// Define VGA_PLOT_SINK_OOB_COUNT_EN to build the saturating out-of-range plot counter.
module vga_plot_sink #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input logic            CLOCK_50,
  input logic            resetn,
  vga_plot_sink_if.slave bus
);

  localparam int unsigned Depth    = WIDTH * HEIGHT;
  localparam logic [14:0] LastAddr = 15'(Depth - 1);
  localparam logic [7:0]  XLim     = 8'(WIDTH);
  localparam logic [6:0]  YLim     = 7'(HEIGHT);

  typedef enum logic {StClear, StRun} state_e;

  state_e      state_q, state_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;
  logic        ready_q, ready_d;
  logic        p1_valid_q, p1_valid_d;
  logic [14:0] p1_addr_q, p1_addr_d;
  logic [2:0]  p1_colour_q, p1_colour_d;
  logic [2:0]  p1_old_q, p1_old_d;
  logic [14:0] lit_q, lit_d;
  logic        rs_valid_q, rs_valid_d;
  logic [2:0]  rs_data_q, rs_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [2:0]  rd_data_q, rd_data_d;

  logic [2:0]  mem [Depth];
  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;

  logic [14:0] plot_addr, rd_addr;
  logic        plot_in_range, rd_in_range, plot_accept, plot_reject;

  function automatic logic [14:0] pix_addr(logic [7:0] x, logic [6:0] y);
    logic [14:0] y15;
    y15 = {8'd0, y};
    return (y15 << 7) + (y15 << 5) + {7'd0, x};
  endfunction

  assign plot_addr     = pix_addr(bus.vga_x, bus.vga_y);
  assign rd_addr       = pix_addr(bus.rd_x, bus.rd_y);
  assign plot_in_range = (bus.vga_x < XLim) && (bus.vga_y < YLim);
  assign rd_in_range   = (bus.rd_x < XLim) && (bus.rd_y < YLim);
  assign plot_accept   = (state_q == StRun) && bus.vga_plot && plot_in_range;
  assign plot_reject   = (state_q == StRun) && bus.vga_plot && !plot_in_range;

  // Clear sweep owns the write port until the last address is zeroed.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = p1_addr_q;
    mem_wdata = p1_colour_q;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = 3'd0;
        if (clr_cnt_q == LastAddr) begin
          state_d   = StRun;
          ready_d   = 1'b1;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 15'd1;
        end
      end
      StRun: mem_we = p1_valid_q;
    endcase
  end

  // P1 samples the old colour; a write still pending in P2 is newer than memory.
  always_comb begin
    p1_valid_d  = plot_accept;
    p1_addr_d   = plot_addr;
    p1_colour_d = bus.vga_colour;
    p1_old_d    = 3'd0;
    if (plot_accept) begin
      if (p1_valid_q && (p1_addr_q == plot_addr)) p1_old_d = p1_colour_q;
      else                                        p1_old_d = mem[plot_addr];
    end

    lit_d = lit_q;
    if (p1_valid_q) begin
      if ((p1_old_q == 3'd0) && (p1_colour_q != 3'd0))      lit_d = lit_q + 15'd1;
      else if ((p1_old_q != 3'd0) && (p1_colour_q == 3'd0)) lit_d = lit_q - 15'd1;
    end
  end

  // Read priority: plot sampled on the same edge, then pending P2 write, then memory.
  always_comb begin
    rs_valid_d = bus.rd_req;
    rs_data_d  = 3'd0;
    if (bus.rd_req && rd_in_range && (state_q == StRun)) begin
      if (plot_accept && (plot_addr == rd_addr))           rs_data_d = bus.vga_colour;
      else if (p1_valid_q && (p1_addr_q == rd_addr))       rs_data_d = p1_colour_q;
      else                                                 rs_data_d = mem[rd_addr];
    end
    rd_valid_d = rs_valid_q;
    rd_data_d  = rs_valid_q ? rs_data_q : 3'd0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      ready_q     <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_addr_q   <= '0;
      p1_colour_q <= '0;
      p1_old_q    <= '0;
      lit_q       <= '0;
      rs_valid_q  <= 1'b0;
      rs_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ready_q     <= ready_d;
      p1_valid_q  <= p1_valid_d;
      p1_addr_q   <= p1_addr_d;
      p1_colour_q <= p1_colour_d;
      p1_old_q    <= p1_old_d;
      lit_q       <= lit_d;
      rs_valid_q  <= rs_valid_d;
      rs_data_q   <= rs_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef VGA_PLOT_SINK_OOB_COUNT_EN
  logic [7:0] oob_q, oob_d;

  always_comb begin
    oob_d = oob_q;
    if (plot_reject && (oob_q != 8'hff)) oob_d = oob_q + 8'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) oob_q <= '0;
    else         oob_q <= oob_d;
  end

  assign bus.oob_count = oob_q;
`else
  logic unused_reject;
  assign unused_reject = plot_reject;
  assign bus.oob_count = 8'd0;
`endif

  assign bus.ready     = ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.lit_count = lit_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Self-checking bench for vga_plot_sink against a whole-screen array model of the framebuffer.
module tb_vga_plot_sink;

`ifdef VGA_PLOT_SINK_OOB_COUNT_EN
  localparam bit OobEn = 1'b1;
`else
  localparam bit OobEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  vga_plot_sink_if bus ();

  vga_plot_sink #(.WIDTH(160), .HEIGHT(120)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [2:0] model [19200];
  int model_oob = 0;
  bit model_run = 1'b0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.vga_plot = 1'b0;
    bus.rd_req   = 1'b0;
  endtask

  function automatic bit in_range(int x, int y);
    return (x < 160) && (y < 120);
  endfunction

  function automatic int lit_model();
    int n = 0;
    for (int i = 0; i < 19200; i++) if (model[i] != 3'd0) n++;
    return n;
  endfunction

  function automatic void model_plot(int x, int y, int c);
    if (!model_run) return;
    if (in_range(x, y)) model[y * 160 + x] = 3'(c);
    else if (OobEn && model_oob < 255) model_oob++;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 19200; i++) model[i] = 3'd0;
    model_oob = 0;
    model_run = 1'b0;
  endfunction

  task automatic drive_plot(input int x, input int y, input int c);
    bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'(c); bus.vga_plot = 1'b1;
  endtask

  task automatic drive_read(input int x, input int y);
    bus.rd_x = 8'(x); bus.rd_y = 7'(y); bus.rd_req = 1'b1;
  endtask

  task automatic plot_cycle(input int x, input int y, input int c);
    drive_plot(x, y, c);
    tick();
    bus.vga_plot = 1'b0;
    model_plot(x, y, c);
  endtask

  task automatic do_read(input int x, input int y, output logic v_early, output logic v,
                         output logic [2:0] d);
    drive_read(x, y);
    tick();
    bus.rd_req = 1'b0;
    v_early = bus.rd_valid;
    tick();
    v = bus.rd_valid;
    d = bus.rd_data;
  endtask

  // Releases reset at a negedge, then counts edges until ready must rise.
  task automatic clear_sweep(input bit plot_during);
    int early = 0;
    resetn = 1'b1;
    for (int n = 1; n <= 19200; n++) begin
      if (plot_during && n == 1) begin
        drive_plot(5, 5, 4);
        drive_read(5, 5);
      end
      tick();
      idle_inputs();
      if (plot_during && n == 2) begin
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 3'd0) begin
          bad++;
          $display("FAIL clear_read: valid=%b data=%0d want valid=1 data=0",
                   bus.rd_valid, bus.rd_data);
        end
      end
      if (n < 19200 && bus.ready !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL ready_early: high for %0d cycles before edge 19200, want 0", early);
    end
    total++;
    if (bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_rise: ready=%b at edge 19200, want 1", bus.ready);
    end
    model_run = 1'b1;
  endtask

  task automatic test_reset();
    logic v0, v;
    logic [2:0] d;
    idle_inputs();
    bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.rd_x = '0; bus.rd_y = '0;
    model_clear();
    tick();
    tick();
    total++;
    if ({bus.ready, bus.rd_valid, bus.rd_data, bus.lit_count, bus.oob_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b rd_valid=%b rd_data=%0d lit=%0d oob=%0d want all 0",
               bus.ready, bus.rd_valid, bus.rd_data, bus.lit_count, bus.oob_count);
    end
    clear_sweep(1'b1);
    tick();
    total++;
    if (bus.lit_count !== 15'd0) begin
      bad++;
      $display("FAIL clear_ignores_plot: lit=%0d want 0", bus.lit_count);
    end
    do_read(5, 5, v0, v, d);
    total++;
    if (v !== 1'b1 || d !== 3'd0) begin
      bad++;
      $display("FAIL clear_pixel: valid=%b data=%0d want valid=1 data=0", v, d);
    end
  endtask

  task automatic test_block();
    logic v0, v;
    logic [2:0] d;
    for (int y = 6; y <= 11; y++)
      for (int x = 3; x <= 8; x++) plot_cycle(x, y, 1);
    tick();
    tick();
    total++;
    if (int'(bus.lit_count) != lit_model() || lit_model() != 36) begin
      bad++;
      $display("FAIL block_lit: lit=%0d want %0d", bus.lit_count, lit_model());
    end
    do_read(8, 11, v0, v, d);
    total++;
    if (v0 !== 1'b0 || v !== 1'b1 || d !== model[11 * 160 + 8]) begin
      bad++;
      $display("FAIL block_read: early=%b valid=%b data=%0d want early=0 valid=1 data=%0d",
               v0, v, d, model[11 * 160 + 8]);
    end
    tick();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_valid_pulse: rd_valid=%b want 0", bus.rd_valid);
    end
  endtask

  task automatic test_same_pixel();
    int prior;
    logic v0, v;
    logic [2:0] d;
    prior = lit_model();
    plot_cycle(10, 10, 2);
    plot_cycle(10, 10, 0);
    tick();
    tick();
    total++;
    if (int'(bus.lit_count) != prior) begin
      bad++;
      $display("FAIL same_pixel_lit: lit=%0d want %0d", bus.lit_count, prior);
    end
    do_read(10, 10, v0, v, d);
    total++;
    if (v !== 1'b1 || d !== 3'd0) begin
      bad++;
      $display("FAIL same_pixel_read: valid=%b data=%0d want valid=1 data=0", v, d);
    end
    plot_cycle(12, 12, 3);
    plot_cycle(12, 12, 5);
    plot_cycle(12, 12, 6);
    tick();
    tick();
    total++;
    if (int'(bus.lit_count) != lit_model()) begin
      bad++;
      $display("FAIL recolour_lit: lit=%0d want %0d", bus.lit_count, lit_model());
    end
  endtask

  task automatic test_oob();
    int prior;
    logic v0, v;
    logic [2:0] d;
    prior = lit_model();
    plot_cycle(160, 0, 7);
    plot_cycle(0, 120, 7);
    plot_cycle(255, 127, 7);
    tick();
    tick();
    total++;
    if (int'(bus.oob_count) != model_oob || model_oob != (OobEn ? 3 : 0)) begin
      bad++;
      $display("FAIL oob_count: oob=%0d want %0d", bus.oob_count, model_oob);
    end
    total++;
    if (int'(bus.lit_count) != prior) begin
      bad++;
      $display("FAIL oob_lit: lit=%0d want %0d", bus.lit_count, prior);
    end
    // (160,0) would alias (0,1) if it were written.
    do_read(0, 1, v0, v, d);
    total++;
    if (v !== 1'b1 || d !== model[160]) begin
      bad++;
      $display("FAIL oob_alias: valid=%b data=%0d want valid=1 data=%0d", v, d, model[160]);
    end
    do_read(200, 5, v0, v, d);
    total++;
    if (v !== 1'b1 || d !== 3'd0) begin
      bad++;
      $display("FAIL oob_read: valid=%b data=%0d want valid=1 data=0", v, d);
    end
  endtask

  task automatic test_forward();
    drive_plot(20, 20, 5);
    drive_read(20, 20);
    tick();
    idle_inputs();
    model_plot(20, 20, 5);
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== model[20 * 160 + 20]) begin
      bad++;
      $display("FAIL forward_same_cycle: valid=%b data=%0d want valid=1 data=%0d",
               bus.rd_valid, bus.rd_data, model[20 * 160 + 20]);
    end
    // Read one cycle after a plot must see the still-pending write.
    plot_cycle(21, 20, 3);
    drive_read(21, 20);
    tick();
    idle_inputs();
    tick();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== model[20 * 160 + 21]) begin
      bad++;
      $display("FAIL forward_pending: valid=%b data=%0d want valid=1 data=%0d",
               bus.rd_valid, bus.rd_data, model[20 * 160 + 21]);
    end
  endtask

  task automatic test_random();
    logic [2:0] exp_q[$];
    logic [2:0] exp_d;
    bit prev_req = 1'b0;
    bit pl, rq;
    int x, y, c, rx, ry;
    for (int i = 0; i < 400; i++) begin
      pl = ($urandom_range(0, 3) != 0);
      rq = ($urandom_range(0, 1) != 0);
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) x = $urandom_range(160, 255);
      c = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
      rx = $urandom_range(0, 15);
      ry = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) ry = $urandom_range(120, 127);
      if (pl) drive_plot(x, y, c);
      if (rq) drive_read(rx, ry);
      tick();
      idle_inputs();
      if (pl) model_plot(x, y, c);
      if (rq) exp_q.push_back(in_range(rx, ry) ? model[ry * 160 + rx] : 3'd0);
      total++;
      if (bus.rd_valid !== prev_req) begin
        bad++;
        $display("FAIL rand_valid[%0d]: rd_valid=%b want %b", i, bus.rd_valid, prev_req);
      end
      if (prev_req) begin
        exp_d = exp_q.pop_front();
        total++;
        if (bus.rd_data !== exp_d) begin
          bad++;
          $display("FAIL rand_data[%0d]: rd_data=%0d want %0d", i, bus.rd_data, exp_d);
        end
      end
      prev_req = rq;
    end
    tick();
    if (prev_req) begin
      exp_d = exp_q.pop_front();
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
        bad++;
        $display("FAIL rand_last: valid=%b data=%0d want valid=1 data=%0d",
                 bus.rd_valid, bus.rd_data, exp_d);
      end
    end
    tick();
    total++;
    if (int'(bus.lit_count) != lit_model()) begin
      bad++;
      $display("FAIL rand_lit: lit=%0d want %0d", bus.lit_count, lit_model());
    end
    total++;
    if (int'(bus.oob_count) != model_oob) begin
      bad++;
      $display("FAIL rand_oob: oob=%0d want %0d", bus.oob_count, model_oob);
    end
  endtask

  task automatic test_oob_saturate();
    for (int i = 0; i < 260; i++) plot_cycle(200, 50, 1);
    tick();
    total++;
    if (int'(bus.oob_count) != model_oob || model_oob != (OobEn ? 255 : 0)) begin
      bad++;
      $display("FAIL oob_saturate: oob=%0d want %0d", bus.oob_count, model_oob);
    end
  endtask

  task automatic test_midstream_reset();
    logic v0, v;
    logic [2:0] d;
    for (int x = 0; x < 50; x++) plot_cycle(x, 30, 7);
    tick();
    tick();
    total++;
    if (int'(bus.lit_count) != lit_model() || lit_model() < 50) begin
      bad++;
      $display("FAIL pre_reset_lit: lit=%0d want %0d", bus.lit_count, lit_model());
    end
    drive_plot(60, 60, 3);
    drive_read(3, 6);
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({bus.ready, bus.rd_valid, bus.rd_data, bus.lit_count, bus.oob_count} !== '0) begin
      bad++;
      $display("FAIL async_reset: ready=%b rd_valid=%b rd_data=%0d lit=%0d oob=%0d want all 0",
               bus.ready, bus.rd_valid, bus.rd_data, bus.lit_count, bus.oob_count);
    end
    model_clear();
    tick();
    idle_inputs();
    tick();
    clear_sweep(1'b0);
    tick();
    do_read(3, 6, v0, v, d);
    total++;
    if (v !== 1'b1 || d !== 3'd0) begin
      bad++;
      $display("FAIL post_reset_read: valid=%b data=%0d want valid=1 data=0", v, d);
    end
    do_read(10, 30, v0, v, d);
    total++;
    if (v !== 1'b1 || d !== 3'd0) begin
      bad++;
      $display("FAIL post_reset_stale: valid=%b data=%0d want valid=1 data=0", v, d);
    end
    total++;
    if (bus.lit_count !== 15'd0 || bus.oob_count !== 8'd0) begin
      bad++;
      $display("FAIL post_reset_counts: lit=%0d oob=%0d want 0 0",
               bus.lit_count, bus.oob_count);
    end
  endtask

  initial begin
    test_reset();
    test_block();
    test_same_pixel();
    test_oob();
    test_forward();
    test_random();
    test_oob_saturate();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_plot_sink.md
# vga_plot_sink

Receiving end of the pixel-plot stream that the tetris top drives into the VGA adapter (x, y, colour, plot strobe on a 160x120 3-bit-colour screen). It captures every plot into a shadow framebuffer and keeps a running count of non-black pixels. It also offers a registered pixel read port. Benches and the on-chip self-check use it to compare the drawn screen against the game board without probing VGA timing.

## Interface
Parameters:
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels

Ports:
- CLOCK_50  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour, 0 = black
- vga_plot  in  1  plot strobe, one pixel per cycle when high
- rd_req  in  1  pixel read request
- rd_x  in  8  read x
- rd_y  in  7  read y
- ready  out  1  high once the post-reset clear sweep is done
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  3  colour read
- lit_count  out  15  number of pixels with colour != 0
- oob_count  out  8  saturating count of rejected out-of-range plots

## Operation
- Address mapping: addr = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x.
- Storage: a 19200 x 3 memory.
- Reset (resetn=0, asynchronous):
  - all registers cleared; ready=0, rd_valid=0, rd_data=0, lit_count=0, oob_count=0
  - any pending pipeline write is discarded
  - state forced to CLEAR
- State CLEAR:
  - sweep counter 0..19199 writes 0, one address per cycle
  - plots are ignored and not counted
  - rd_req still answered, rd_data=0
  - after address 19199 is written, go to RUN; ready=1 from the next cycle
- State RUN:
  - a plot with x<WIDTH and y<HEIGHT is accepted
  - a plot with x>=WIDTH or y>=HEIGHT is rejected; oob_count+1, saturating at 255
- Plot pipeline, two stages:
  - P1 registers addr and colour and reads the old colour
  - P2 writes the new colour and updates lit_count
  - lit_count +1 when old==0 and new!=0; -1 when old!=0 and new==0; otherwise unchanged
- Hazard: if the P1 address equals the pending P2 address, the old colour is forwarded from P2, not from memory. Back-to-back plots to one pixel must count correctly.
- Read port:
  - rd_data returns the colour of the most recent accepted plot sampled at or before the rd_req edge
  - pending P1/P2 writes are forwarded
  - an out-of-range read returns 0 and still pulses rd_valid
- A read and a plot in the same cycle are both served; no stall and no backpressure.

## Timing
- Plot sampled at edge t: memory and lit_count are updated at edge t+1.
- rd_req sampled at edge t: rd_valid=1 and rd_data valid in the cycle after edge t+1. rd_valid is low otherwise.
- Clear sweep: exactly 19200 cycles after resetn deasserts. ready rises at edge 19200.
- Throughput: one plot and one read per cycle, sustained.
- Same-address plots on consecutive cycles: lit_count reflects both after edge t+2.

## Configuration
- VGA_PLOT_SINK_OOB_COUNT_EN defined: oob_count is a live saturating 8-bit counter as above.
- Not defined: oob_count is tied to 0 and no counter logic is built. Out-of-range plots are still rejected and never written.

## Test plan
- Deassert resetn, then plot (5,5,colour 4) during the clear sweep → pixel reads 0, lit_count=0. ready rises exactly 19200 cycles after release.
- After ready, plot (3,6)..(8,11) all colour 1 (36 pixels) → lit_count=36. rd at (8,11) gives rd_data=1 two edges after rd_req.
- Plot (10,10)=2 and then (10,10)=0 on consecutive cycles → lit_count returns to its prior value. rd (10,10)=0.
- Plot (160,0), (0,120) and (255,127) → oob_count=3 with the macro defined, 0 without it. lit_count unchanged, no memory write.
- Plot (20,20)=5 and rd_req (20,20) in the same cycle → rd_data=5 (forwarded).
- Pulse resetn low mid-stream with 50 pixels lit → all outputs 0 immediately, ready low, and a new 19200-cycle clear runs. Afterwards rd (3,6)=0 and lit_count=0.
